// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, one-hot FSM states and flag positions shared by the sequential ALU.
package seq_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_NAND = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_ROL  = 4'h7;
  localparam logic [3:0] OP_ROR  = 4'h8;
  localparam logic [3:0] OP_SWAP = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_ADDC = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_ASR  = 4'hE;
  localparam logic [3:0] OP_XOR  = 4'hF;
  typedef enum logic [4:0] {
    LOAD_A  = 5'b00001,
    LOAD_B  = 5'b00010,
    LOAD_OP = 5'b00100,
    EXEC    = 5'b01000,
    SHIFT   = 5'b10000
  } state_t;
  localparam int F_N    = 3;
  localparam int F_Z    = 2;
  localparam int F_C    = 1;
  localparam int F_DONE = 0;
  function automatic logic [3:0] mk_flags(input logic n, input logic z, input logic c, input logic d);
    mk_flags = '0;
    mk_flags[F_N] = n;
    mk_flags[F_Z] = z;
    mk_flags[F_C] = c;
    mk_flags[F_DONE] = d;
  endfunction
endpackage

// File: rtl/seq_alu_param_if.sv
// seq_alu_param_if: beat/operand bus into the sequential ALU and its result/flag outputs.
interface seq_alu_param_if #(parameter int WIDTH = 8, parameter int DIN_W = 4);
  logic             enable;
  logic [DIN_W-1:0] data_in;
  logic             chain;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;
  modport master(output enable, data_in, chain, input result, flags, busy);
  modport slave(input enable, data_in, chain, output result, flags, busy);
endinterface

// File: rtl/seq_alu_comb.sv
// seq_alu_comb: single-cycle op evaluation; shift opcodes pass op1 through (zero-amount case).
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic             cout
);
  localparam int H = WIDTH / 2;
  logic [WIDTH:0] sum, dif;
  always_comb begin
    sum  = {1'b0, op1} + {1'b0, op2} + (WIDTH+1)'(opcode == OP_ADDC && cin);
    dif  = {1'b0, op1} - {1'b0, op2};
    res  = '0;
    cout = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC: begin res = sum[WIDTH-1:0]; cout = sum[WIDTH]; end
      OP_SUB:  begin res = dif[WIDTH-1:0]; cout = dif[WIDTH]; end
      OP_AND:  res = op1 & op2;
      OP_OR:   res = op1 | op2;
      OP_NOT:  res = ~op1;
      OP_NAND: res = ~(op1 & op2);
      OP_NOR:  res = ~(op1 | op2);
      OP_ROL:  res = {op1[WIDTH-2:0], op1[WIDTH-1]};
      OP_ROR:  res = {op1[0], op1[WIDTH-1:1]};
      OP_SWAP: res = {op1[H-1:0], op1[WIDTH-1:H]};
      OP_CMP:  res = op1 == op2 ? WIDTH'(1) : op1 < op2 ? WIDTH'(2) : WIDTH'(4);
      OP_SHL, OP_SHR, OP_ASR: res = op1;
      OP_XOR:  res = op1 ^ op2;
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/seq_alu_param.sv
// seq_alu_param: chunk-loaded sequential ALU with chain mode and one-bit-per-clock shifts.
module seq_alu_param
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIN_W = 4
) (
  input logic          clk,
  input logic          reset_n,
  seq_alu_param_if.slave bus
);
  localparam int NB = WIDTH / DIN_W;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam int SW = $clog2(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    scnt, k;
  logic [WIDTH-1:0] op1, op2, result, alu_res, sh_res;
  logic [3:0]       opcode, flags, alu_flags;
  logic             busy, alu_c, sh_c, is_shift, last;
  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op1(op1), .op2(op2), .opcode(opcode), .cin(flags[F_C]), .res(alu_res), .cout(alu_c)
  );
  assign k         = op2[SW-1:0];
  assign last      = cnt == CW'(NB - 1);
  assign is_shift  = opcode == OP_SHL || opcode == OP_SHR || opcode == OP_ASR;
  assign sh_res    = opcode == OP_SHL ? {result[WIDTH-2:0], 1'b0}
                                      : {opcode == OP_ASR && result[WIDTH-1], result[WIDTH-1:1]};
  assign sh_c      = opcode == OP_SHL ? result[WIDTH-1] : result[0];
  // CMP reports its relation through N/Z rather than the generic result-derived flags
  assign alu_flags = opcode == OP_CMP ? mk_flags(alu_res[1], alu_res[0], 1'b0, 1'b1)
                                      : mk_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, 1'b1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= LOAD_A;
      cnt    <= '0;
      scnt   <= '0;
      op1    <= '0;
      op2    <= '0;
      opcode <= '0;
      result <= '0;
      flags  <= '0;
      busy   <= 1'b0;
    end else if (state == SHIFT) begin
      result <= sh_res;
      scnt   <= scnt - 1'b1;
      if (scnt == SW'(1)) begin
        busy  <= 1'b0;
        flags <= mk_flags(sh_res[WIDTH-1], sh_res == '0, sh_c, 1'b1);
        state <= LOAD_A;
      end
    end else if (bus.enable) begin
      case (state)
        LOAD_A: begin
          flags[F_DONE] <= 1'b0;
          if (bus.chain && cnt == '0) begin
            op1   <= result;
            state <= LOAD_B;
          end else begin
            op1[DIN_W*int'(cnt) +: DIN_W] <= bus.data_in;
            cnt   <= last ? '0 : cnt + 1'b1;
            state <= last ? LOAD_B : LOAD_A;
          end
        end
        LOAD_B: begin
          op2[DIN_W*int'(cnt) +: DIN_W] <= bus.data_in;
          cnt   <= last ? '0 : cnt + 1'b1;
          state <= last ? LOAD_OP : LOAD_B;
        end
        LOAD_OP: begin
          opcode <= bus.data_in[3:0];
          state  <= EXEC;
        end
        EXEC: begin
          if (is_shift && k != '0) begin
            result <= op1;
            scnt   <= k;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            result <= alu_res;
            flags  <= alu_flags;
            state  <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end
  assign bus.result = result;
  assign bus.flags  = flags;
  assign bus.busy   = busy;
endmodule

// File: tb/tb_seq_alu_param.sv
// tb_seq_alu_param: randomized and directed transactions checked every cycle against a behavioural ALU model.
module tb_seq_alu_param;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  seq_alu_param_if #(.WIDTH(W), .DIN_W(D)) bus ();
  seq_alu_param #(.WIDTH(W), .DIN_W(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [7:0] er;
  logic [3:0] ef;
  logic       eb;
  bit         live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("result", 32'(bus.result), 32'(er));
      chk("flags", 32'(bus.flags), 32'(ef));
      chk("busy", 32'(bus.busy), 32'(eb));
    end
  end

  function automatic logic [7:0] shift_val(input logic [7:0] a, input logic [3:0] op, input int i);
    logic signed [7:0] sa;
    sa = $signed(a);
    shift_val = op == 4'hC ? 8'(a << i) : op == 4'hD ? 8'(a >> i) : 8'(sa >>> i);
  endfunction

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                 input logic cin, output logic [7:0] r, output logic [3:0] f, output int k);
    int s;
    logic c;
    s = 0;
    c = 1'b0;
    k = 0;
    if (op == 4'hC || op == 4'hD || op == 4'hE) begin
      k = int'(b[2:0]);
      r = shift_val(a, op, k);
      c = k == 0 ? 1'b0 : op == 4'hC ? a[8-k] : a[k-1];
    end else begin
      case (op)
        4'h0: begin s = int'(a) + int'(b); c = s > 255; end
        4'h1: begin s = int'(a) - int'(b); c = a < b; end
        4'h2: s = int'(a & b);
        4'h3: s = int'(a | b);
        4'h4: s = 255 - int'(a);
        4'h5: s = 255 - int'(a & b);
        4'h6: s = 255 - int'(a | b);
        4'h7: s = int'(a) * 2 + int'(a) / 128;
        4'h8: s = int'(a) / 2 + (int'(a) % 2) * 128;
        4'h9: s = (int'(a) % 16) * 16 + int'(a) / 16;
        4'hA: s = a == b ? 1 : a < b ? 2 : 4;
        4'hB: begin s = int'(a) + int'(b) + int'(cin); c = s > 255; end
        default: s = int'(a ^ b);
      endcase
      r = s[7:0];
    end
    f = {r[7], r == 8'h00, c, 1'b1};
    if (op == 4'hA) f = {a < b, a == b, 1'b0, 1'b1};
  endfunction

  task automatic step(input logic en, input logic [3:0] d, input logic ch);
    bus.enable  = en;
    bus.data_in = d;
    bus.chain   = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'($urandom), 1'($urandom));
  endtask

  task automatic run_op(input logic [7:0] a_in, input logic [7:0] b, input logic [3:0] op,
                        input bit ch, input int gaps, input int max_sh);
    logic [7:0] a, r;
    logic [3:0] f;
    int k;
    a = a_in;
    if (ch) begin
      idle(gaps);
      a = er;
      step(1'b1, 4'($urandom), 1'b1);
      ef[0] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        idle(gaps);
        step(1'b1, a[4*i +: 4], i == 1 ? 1'($urandom) : 1'b0);
        ef[0] = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      idle(gaps);
      step(1'b1, b[4*i +: 4], 1'($urandom));
    end
    idle(gaps);
    step(1'b1, op, 1'($urandom));
    idle(gaps);
    ref_op(a, b, op, ef[1], r, f, k);
    step(1'b1, 4'($urandom), 1'($urandom));
    if (k == 0) begin
      er = r;
      ef = f;
    end else begin
      er = a;
      eb = 1'b1;
      for (int i = 1; i <= k && i <= max_sh; i++) begin
        step(1'($urandom), 4'($urandom), 1'($urandom));
        er = shift_val(a, op, i);
        if (i == k) begin
          eb = 1'b0;
          ef = f;
        end
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.data_in = '0;
    bus.chain = 1'b0;
    reset_n = 1'b1;
    er = '0;
    ef = '0;
    eb = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    live = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_result", 32'(bus.result), 32'h0);
    chk("reset_flags", 32'(bus.flags), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    run_op(8'hF0, 8'h20, 4'h0, 1'b0, 0, 99);
    chk("add_result", 32'(bus.result), 32'h10);
    chk("add_flags", 32'(bus.flags), 32'b0011);
    run_op(8'h00, 8'h01, 4'hB, 1'b1, 0, 99);
    chk("chain_addc_result", 32'(bus.result), 32'h12);
    chk("chain_addc_flags", 32'(bus.flags), 32'b0001);
    run_op(8'h05, 8'h07, 4'h1, 1'b0, 0, 99);
    chk("sub_result", 32'(bus.result), 32'hFE);
    chk("sub_flags", 32'(bus.flags), 32'b1011);
    run_op(8'h33, 8'h33, 4'hA, 1'b0, 0, 99);
    chk("cmp_result", 32'(bus.result), 32'h01);
    chk("cmp_flags", 32'(bus.flags), 32'b0101);
    run_op(8'h81, 8'h03, 4'hC, 1'b0, 0, 99);
    chk("shl_result", 32'(bus.result), 32'h08);
    chk("shl_flags", 32'(bus.flags), 32'b0001);
    run_op(8'h80, 8'h02, 4'hE, 1'b0, 0, 99);
    chk("asr_result", 32'(bus.result), 32'hE0);
    chk("asr_flags", 32'(bus.flags), 32'b1001);
    run_op(8'h5A, 8'h3C, 4'h0, 1'b0, 0, 99);
    chk("contig_result", 32'(bus.result), 32'h96);
    run_op(8'h5A, 8'h3C, 4'h0, 1'b0, 2, 99);
    chk("gapped_result", 32'(bus.result), 32'h96);
    chk("gapped_flags", 32'(bus.flags), 32'b1001);
    run_op(8'h81, 8'h07, 4'hC, 1'b0, 0, 2);
    chk("midshift_busy", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    er = '0;
    ef = '0;
    eb = 1'b0;
    #1;
    chk("async_rst_result", 32'(bus.result), 32'h0);
    chk("async_rst_flags", 32'(bus.flags), 32'h0);
    chk("async_rst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    run_op(8'h12, 8'h34, 4'h0, 1'b0, 0, 99);
    chk("post_rst_result", 32'(bus.result), 32'h46);
    chk("post_rst_flags", 32'(bus.flags), 32'b0001);
    for (int n = 0; n < 200; n++)
      run_op(8'($urandom), 8'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 2), 99);
    live = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
